mem_access_ctrl: RTL and testbench

//  Parametrised successor to the 2-bit operation/select memory FSM.

---
 rtl/mem_access_pkg.sv | 22 ++
 rtl/mem_array.sv | 26 ++
 rtl/mem_access_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access controller.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } mac_state_e;

  // Width of the ACCESS dwell counter; covers WAIT_CYCLES up to 15.
  localparam int WAIT_W = 4;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PARITY_MAX_W = 64;

  // Even-parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x WORD_W register-file storage: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Word write; the controller only enables it for in-range addresses.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: req/ready accept, programmable access dwell,
// valid/ack response. Optional per-word even parity when
// MEM_ACCESS_CTRL_PARITY_EN is defined (adds the i_flip_parity test input).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; op/addr/wdata captured on accept
// SETUP  | range check latched, dwell counter loaded
// ACCESS | dwell WAIT_CYCLES cycles; last cycle commits write / samples read
// RESP   | response valid and stable until acknowledged
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_operation,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ack,
`ifdef MEM_ACCESS_CTRL_PARITY_EN
  input  logic              i_flip_parity,
`endif
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_busy
);

`ifdef MEM_ACCESS_CTRL_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  mac_state_e        state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              addr_err_q, addr_err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
`ifdef MEM_ACCESS_CTRL_PARITY_EN
  logic              flip_q, flip_d;
`endif

  logic              mem_we;
  logic [WORD_W-1:0] mem_wword;
  logic [WORD_W-1:0] mem_rword;
  logic              par_mismatch;

  mem_array #(
    .WORD_W(WORD_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem_array (
    .i_clock(i_clock),
    .i_we   (mem_we),
    .i_waddr(addr_q),
    .i_wdata(mem_wword),
    .i_raddr(addr_q),
    .o_rdata(mem_rword)
  );

  // Stored word and read-side parity check.
  always_comb begin
    par_mismatch = 1'b0;
`ifdef MEM_ACCESS_CTRL_PARITY_EN
    mem_wword    = {even_parity(PARITY_MAX_W'(wdata_q)) ^ flip_q, wdata_q};
    par_mismatch = even_parity(PARITY_MAX_W'(mem_rword[DATA_W-1:0])) != mem_rword[DATA_W];
`else
    mem_wword    = wdata_q;
`endif
  end

  // Next-state, capture, dwell counter and response computation.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    addr_err_d = addr_err_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;
`ifdef MEM_ACCESS_CTRL_PARITY_EN
    flip_d     = flip_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          state_d = SETUP;
          op_d    = i_operation;
          addr_d  = i_addr;
          wdata_d = i_wdata;
`ifdef MEM_ACCESS_CTRL_PARITY_EN
          flip_d  = i_flip_parity;
`endif
        end
      end
      SETUP: begin
        addr_err_d = int'(addr_q) >= DEPTH;
        wait_cnt_d = WAIT_W'(WAIT_CYCLES - 1);
        state_d    = ACCESS;
      end
      ACCESS: begin
        if (wait_cnt_q == '0) begin
          state_d = RESP;
          // A reset landing on the commit edge drops the write.
          mem_we  = op_q && !addr_err_q && !i_reset;
          if (addr_err_q) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (op_q) begin
            rdata_d = wdata_q;
            err_d   = 1'b0;
          end else begin
            rdata_d = mem_rword[DATA_W-1:0];
            err_d   = par_mismatch;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      RESP: begin
        if (i_ack) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      addr_err_q <= 1'b0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef MEM_ACCESS_CTRL_PARITY_EN
      flip_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      addr_err_q <= addr_err_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef MEM_ACCESS_CTRL_PARITY_EN
      flip_q     <= flip_d;
`endif
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = !o_ready;
  assign o_valid = (state_q == RESP);
  assign o_rdata = rdata_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (DEPTH=6/WAIT=1 and DEPTH=8/WAIT=4)
// checked every cycle against a transaction-level model, plus literal checks.
// Build with MEM_ACCESS_CTRL_PARITY_EN defined to cover the parity feature.
module tb_mem_access_ctrl;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req   [N];
  logic       op    [N];
  logic       ack   [N];
  logic       flip  [N];
  logic [2:0] addr  [N];
  logic [7:0] wdata [N];
  logic       ready [N];
  logic       valid [N];
  logic       err   [N];
  logic       busy  [N];
  logic [7:0] rdata [N];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  mem_access_ctrl #(.DATA_W(8), .DEPTH(6), .WAIT_CYCLES(1)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_req(req[0]), .i_operation(op[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0]), .i_ack(ack[0]),
`ifdef MEM_ACCESS_CTRL_PARITY_EN
    .i_flip_parity(flip[0]),
`endif
    .o_ready(ready[0]), .o_valid(valid[0]), .o_rdata(rdata[0]),
    .o_err(err[0]), .o_busy(busy[0])
  );

  mem_access_ctrl #(.DATA_W(8), .DEPTH(8), .WAIT_CYCLES(4)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_req(req[1]), .i_operation(op[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .i_ack(ack[1]),
`ifdef MEM_ACCESS_CTRL_PARITY_EN
    .i_flip_parity(flip[1]),
`endif
    .o_ready(ready[1]), .o_valid(valid[1]), .o_rdata(rdata[1]),
    .o_err(err[1]), .o_busy(busy[1])
  );

  function automatic int dep(input int i);
    return (i == 0) ? 6 : 8;
  endfunction

  function automatic int wt(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic check(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h", nm, i, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit         m_busy  [N];
  bit         m_resp  [N];
  int         m_ph    [N];
  bit         m_op    [N];
  logic [2:0] m_addr  [N];
  logic [7:0] m_wd    [N];
  bit         m_fl    [N];
  logic [7:0] m_rd    [N];
  bit         m_err   [N];
  bit         m_chk   [N];
  logic [7:0] m_mem   [N][8];
  bit         m_par   [N][8];
  bit         m_known [N][8];

  // Response appears 2+WAIT cycles after the request cycle; writes land then.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
        m_resp[i] = 1'b0;
        m_ph[i]   = 0;
      end else if (!m_busy[i]) begin
        if (req[i]) begin
          m_busy[i] = 1'b1;
          m_ph[i]   = 1;
          m_op[i]   = op[i];
          m_addr[i] = addr[i];
          m_wd[i]   = wdata[i];
          m_fl[i]   = flip[i];
        end
      end else if (m_resp[i]) begin
        if (ack[i]) begin
          m_busy[i] = 1'b0;
          m_resp[i] = 1'b0;
        end
      end else begin
        m_ph[i]++;
        if (m_ph[i] == 2 + wt(i)) begin
          m_resp[i] = 1'b1;
          if (int'(m_addr[i]) >= dep(i)) begin
            m_rd[i] = 8'h00; m_err[i] = 1'b1; m_chk[i] = 1'b1;
          end else if (m_op[i]) begin
            m_mem[i][m_addr[i]]   = m_wd[i];
            m_par[i][m_addr[i]]   = (^m_wd[i]) ^ m_fl[i];
            m_known[i][m_addr[i]] = 1'b1;
            m_rd[i] = m_wd[i]; m_err[i] = 1'b0; m_chk[i] = 1'b1;
          end else begin
            m_rd[i]  = m_mem[i][m_addr[i]];
`ifdef MEM_ACCESS_CTRL_PARITY_EN
            m_err[i] = (^m_mem[i][m_addr[i]]) != m_par[i][m_addr[i]];
`else
            m_err[i] = 1'b0;
`endif
            m_chk[i] = m_known[i][m_addr[i]];
          end
        end
      end
    end
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check("ready", i, 8'(ready[i]), 8'(!m_busy[i]));
        check("busy",  i, 8'(busy[i]),  8'(m_busy[i]));
        check("valid", i, 8'(valid[i]), 8'(m_resp[i]));
        if (m_resp[i] && m_chk[i]) begin
          check("rdata", i, rdata[i], m_rd[i]);
          check("err",   i, 8'(err[i]), 8'(m_err[i]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input int i, input bit o, input logic [2:0] a, input logic [7:0] d,
                     input bit fl, input int ack_dly,
                     output logic [7:0] rd, output logic er, output int lat);
    @(negedge clk);
    req[i] = 1'b1; op[i] = o; addr[i] = a; wdata[i] = d; flip[i] = fl;
    lat = 0;
    do begin
      @(negedge clk);
      req[i] = 1'b0;
      lat++;
    end while (!valid[i] && lat < 40);
    if (!valid[i]) begin
      n_tests++; n_fail++;
      $display("FAIL txn_timeout inst%0d: no o_valid after %0d cycles", i, lat);
    end
    rd = rdata[i];
    er = err[i];
    repeat (ack_dly) @(negedge clk);
    ack[i] = 1'b1;
    @(negedge clk);
    ack[i] = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat;
    int         k;

    for (int i = 0; i < N; i++) begin
      req[i] = 0; op[i] = 0; ack[i] = 0; flip[i] = 0; addr[i] = 0; wdata[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // 1: idle after reset
    for (int i = 0; i < N; i++) begin
      check("rst_ready", i, 8'(ready[i]), 8'd1);
      check("rst_valid", i, 8'(valid[i]), 8'd0);
      check("rst_rdata", i, rdata[i], 8'h00);
      check("rst_err",   i, 8'(err[i]), 8'd0);
      check("rst_busy",  i, 8'(busy[i]), 8'd0);
    end

    // 2: write then read addr 3, WAIT=1
    txn(0, 1'b1, 3'd3, 8'hA5, 1'b0, 0, rd, er, lat);
    check("wr3_lat", 0, 8'(lat), 8'd3);
    txn(0, 1'b0, 3'd3, 8'h00, 1'b0, 0, rd, er, lat);
    check("rd3_data", 0, rd, 8'hA5);
    check("rd3_err",  0, 8'(er), 8'd0);
    check("rd3_lat",  0, 8'(lat), 8'd3);

    // 4: fill DEPTH=6, out-of-range write, readback unchanged
    for (int w = 0; w < 6; w++)
      txn(0, 1'b1, 3'(w), 8'(8'h11 * (w + 1)), 1'b0, 0, rd, er, lat);
    txn(0, 1'b1, 3'd7, 8'hFF, 1'b0, 0, rd, er, lat);
    check("oor_err",   0, 8'(er), 8'd1);
    check("oor_rdata", 0, rd, 8'h00);
    for (int w = 0; w < 6; w++) begin
      txn(0, 1'b0, 3'(w), 8'h00, 1'b0, 0, rd, er, lat);
      check("fill_rd", 0, rd, 8'(8'h11 * (w + 1)));
    end

    // 3: WAIT=4 latency and held response
    txn(1, 1'b1, 3'd0, 8'h5A, 1'b0, 0, rd, er, lat);
    check("w4_wr_lat", 1, 8'(lat), 8'd6);
    txn(1, 1'b0, 3'd0, 8'h00, 1'b0, 5, rd, er, lat);
    check("w4_rd_lat",  1, 8'(lat), 8'd6);
    check("w4_rd_data", 1, rd, 8'h5A);
    check("w4_idle_after_ack", 1, 8'(ready[1]), 8'd1);

    // 5a: request pulse during ACCESS is ignored
    @(negedge clk);
    req[1] = 1'b1; op[1] = 1'b0; addr[1] = 3'd0;
    @(negedge clk); req[1] = 1'b0;
    @(negedge clk);
    req[1] = 1'b1; op[1] = 1'b1; addr[1] = 3'd0; wdata[1] = 8'hEE;
    @(negedge clk); req[1] = 1'b0;
    k = 0;
    while (!valid[1] && k < 40) begin @(negedge clk); k++; end
    check("pulse_rdata", 1, rdata[1], 8'h5A);
    ack[1] = 1'b1; @(negedge clk); ack[1] = 1'b0;
    repeat (8) @(negedge clk);
    txn(1, 1'b0, 3'd0, 8'h00, 1'b0, 0, rd, er, lat);
    check("pulse_mem_kept", 1, rd, 8'h5A);

    // 5b: reset during ACCESS drops the write
    @(negedge clk);
    req[0] = 1'b1; op[0] = 1'b1; addr[0] = 3'd2; wdata[0] = 8'h3C;
    @(negedge clk); req[0] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_acc_ready", 0, 8'(ready[0]), 8'd1);
    check("rst_acc_valid", 0, 8'(valid[0]), 8'd0);
    txn(0, 1'b0, 3'd2, 8'h00, 1'b0, 0, rd, er, lat);
    check("rst_acc_kept", 0, rd, 8'h33);

`ifdef MEM_ACCESS_CTRL_PARITY_EN
    // 6: forced parity error, then clean rewrite
    txn(0, 1'b1, 3'd1, 8'h0F, 1'b1, 0, rd, er, lat);
    txn(0, 1'b0, 3'd1, 8'h00, 1'b0, 0, rd, er, lat);
    check("par_err",   0, 8'(er), 8'd1);
    check("par_rdata", 0, rd, 8'h0F);
    txn(0, 1'b1, 3'd1, 8'h0F, 1'b0, 0, rd, er, lat);
    txn(0, 1'b0, 3'd1, 8'h00, 1'b0, 0, rd, er, lat);
    check("par_ok_err",   0, 8'(er), 8'd0);
    check("par_ok_rdata", 0, rd, 8'h0F);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
